// File: rtl/apb_pkg.sv
// Shared types for the two-requester APB master.
// Field widths of req_t follow the default build widths.
package apb_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int SEL_W_DEF  = 2;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   typedef struct packed {
      logic                  write;
      logic [SEL_W_DEF-1:0]  sel;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } req_t;

endpackage

// File: rtl/apb_arb_master_if.sv
// Request ports and APB bus of the arbitrating master.
// master = the arbiter/bus driver, slave = requesters plus slave array.
interface apb_arb_master_if
   import apb_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int NUM_SLV = 3
);

   logic                      req0_valid;
   logic                      req1_valid;
   logic                      req0_write;
   logic                      req1_write;
   logic [SEL_W+ADDR_W-1:0]   req0_addr;
   logic [SEL_W+ADDR_W-1:0]   req1_addr;
   logic [DATA_W-1:0]         req0_wdata;
   logic [DATA_W-1:0]         req1_wdata;
   logic                      req0_ack;
   logic                      req1_ack;
   logic                      req0_done;
   logic                      req1_done;
   logic                      req0_err;
   logic                      req1_err;
   logic [DATA_W-1:0]         rdata;
   logic [NUM_SLV-1:0]        Psel;
   logic                      Penable;
   logic                      Pwrite;
   logic [ADDR_W-1:0]         Paddr;
   logic [DATA_W-1:0]         Pwdata;
   logic [NUM_SLV*DATA_W-1:0] Prdata_bus;
   logic [NUM_SLV-1:0]        Pready_bus;

   modport master (
      input  req0_valid, req1_valid, req0_write, req1_write,
      input  req0_addr, req1_addr, req0_wdata, req1_wdata,
      output req0_ack, req1_ack, req0_done, req1_done,
      output req0_err, req1_err, rdata,
      output Psel, Penable, Pwrite, Paddr, Pwdata,
      input  Prdata_bus, Pready_bus
   );

   modport slave (
      output req0_valid, req1_valid, req0_write, req1_write,
      output req0_addr, req1_addr, req0_wdata, req1_wdata,
      input  req0_ack, req1_ack, req0_done, req1_done,
      input  req0_err, req1_err, rdata,
      input  Psel, Penable, Pwrite, Paddr, Pwdata,
      output Prdata_bus, Pready_bus
   );

endinterface

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter; last_grant resets to 1 so port 0 wins the first tie.
module apb_rr_arb (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic       grant_en_i,
   output logic [1:0] grant_o
);

   logic last_q, last_d;

   always_comb begin
      grant_o = 2'b00;
      unique case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (grant_en_i && |valid_i) last_d = grant_o[1];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) last_q <= 1'b1;
      else       last_q <= last_d;
   end

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: arbitration, slave decode, IDLE/SETUP/ACCESS/RESP.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT Pready-low cycles.
module apb_arb_master
   import apb_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int SEL_W   = SEL_W_DEF,
`ifdef APB_TIMEOUT_EN
   parameter int TIMEOUT = 31,
`endif
   parameter int NUM_SLV = 3
) (
   input logic              Pclk,
   input logic              Prst,
   apb_arb_master_if.master bus
);

   state_t             state_q, state_d;
   req_t               req_q, req_d, pick;
   logic               gid_q, gid_d;
   logic               err_q, err_d;
   logic [1:0]         ack_q, ack_d;
   logic [1:0]         done_q, done_d;
   logic [1:0]         erro_q, erro_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [NUM_SLV-1:0] psel_q, psel_d;
   logic               pen_q, pen_d;
   logic [1:0]         gnt;
   logic               sel_ok;
   logic               rdy;
   logic               tmo;

   apb_rr_arb u_arb (
      .clk_i      (Pclk),
      .rst_i      (Prst),
      .valid_i    ({bus.req1_valid, bus.req0_valid}),
      .grant_en_i (state_q == IDLE),
      .grant_o    (gnt)
   );

   always_comb begin
      pick = '0;
      if (gnt[1]) begin
         pick.write = bus.req1_write;
         pick.sel   = bus.req1_addr[ADDR_W +: SEL_W];
         pick.addr  = bus.req1_addr[ADDR_W-1:0];
         pick.wdata = bus.req1_wdata;
      end else begin
         pick.write = bus.req0_write;
         pick.sel   = bus.req0_addr[ADDR_W +: SEL_W];
         pick.addr  = bus.req0_addr[ADDR_W-1:0];
         pick.wdata = bus.req0_wdata;
      end
   end

   assign sel_ok = int'(pick.sel) < NUM_SLV;
   assign rdy    = bus.Pready_bus[req_q.sel];

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_q, wait_d;

   // Fires on the TIMEOUT-th consecutive Pready-low ACCESS cycle.
   assign tmo = (state_q == ACCESS) && !rdy &&
                (wait_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      wait_d = wait_q;
      if (state_q == SETUP) wait_d = '0;
      else if (state_q == ACCESS && !rdy) wait_d = wait_q + 1'b1;
   end

   always_ff @(posedge Pclk) begin
      if (Prst) wait_q <= '0;
      else      wait_q <= wait_d;
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge Pclk) begin
      if (Prst) begin
         state_q <= IDLE;
         req_q   <= '0;
         gid_q   <= 1'b0;
         err_q   <= 1'b0;
         ack_q   <= '0;
         done_q  <= '0;
         erro_q  <= '0;
         rdata_q <= '0;
         psel_q  <= '0;
         pen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         gid_q   <= gid_d;
         err_q   <= err_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         erro_q  <= erro_d;
         rdata_q <= rdata_d;
         psel_q  <= psel_d;
         pen_q   <= pen_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|gnt) state_d = sel_ok ? SETUP : RESP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (rdy || tmo) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_d   = req_q;
      gid_d   = gid_q;
      err_d   = err_q;
      ack_d   = '0;
      done_d  = '0;
      erro_d  = '0;
      rdata_d = rdata_q;
      psel_d  = psel_q;
      pen_d   = pen_q;
      unique case (state_q)
         IDLE: if (|gnt) begin
            req_d = pick;
            gid_d = gnt[1];
            err_d = !sel_ok;
            ack_d = gnt;
            if (sel_ok) psel_d = {{(NUM_SLV-1){1'b0}}, 1'b1} << pick.sel;
         end
         SETUP: pen_d = 1'b1;
         ACCESS: if (rdy) begin
            psel_d = '0;
            pen_d  = 1'b0;
            if (!req_q.write)
               rdata_d = bus.Prdata_bus[int'(req_q.sel)*DATA_W +: DATA_W];
         end else if (tmo) begin
            psel_d  = '0;
            pen_d   = 1'b0;
            err_d   = 1'b1;
            rdata_d = '0;
         end
         RESP: begin
            done_d[gid_q] = 1'b1;
            erro_d[gid_q] = err_q;
         end
         default: ;
      endcase
   end

   assign bus.req0_ack  = ack_q[0];
   assign bus.req1_ack  = ack_q[1];
   assign bus.req0_done = done_q[0];
   assign bus.req1_done = done_q[1];
   assign bus.req0_err  = erro_q[0];
   assign bus.req1_err  = erro_q[1];
   assign bus.rdata     = rdata_q;
   assign bus.Psel      = psel_q;
   assign bus.Penable   = pen_q;
   assign bus.Pwrite    = req_q.write;
   assign bus.Paddr     = req_q.addr;
   assign bus.Pwdata    = req_q.wdata;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: writes, waited reads, contention,
// decode error, mid-transfer reset and the ACCESS wait limit.
module tb_apb_arb_master;

   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;
   int   g[$];

   apb_arb_master_if #(.DATA_W(16), .ADDR_W(3), .SEL_W(2), .NUM_SLV(3)) bus ();

   apb_arb_master #(.DATA_W(16), .ADDR_W(3), .SEL_W(2), .NUM_SLV(3)) dut (
      .Pclk (clk),
      .Prst (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // {ack1,ack0,done1,done0,err1,err0,Penable,Pwrite,Psel}
   function automatic logic [31:0] ctl();
      return {21'd0, bus.req1_ack, bus.req0_ack, bus.req1_done,
              bus.req0_done, bus.req1_err, bus.req0_err,
              bus.Penable, bus.Pwrite, bus.Psel};
   endfunction

   function automatic logic [31:0] mk(input logic a1, input logic a0,
                                      input logic d1, input logic d0,
                                      input logic e1, input logic e0,
                                      input logic pen, input logic pw,
                                      input logic [2:0] ps);
      return {21'd0, a1, a0, d1, d0, e1, e0, pen, pw, ps};
   endfunction

   initial begin
      rst            = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_write = 1'b0;
      bus.req1_write = 1'b0;
      bus.req0_addr  = '0;
      bus.req1_addr  = '0;
      bus.req0_wdata = '0;
      bus.req1_wdata = '0;
      bus.Prdata_bus = {16'hBEEF, 16'h5555, 16'h1234};
      bus.Pready_bus = 3'b000;
      tick(2);
      chk("reset_ctl", ctl(), 32'd0);
      chk("reset_data", {bus.rdata, bus.Pwdata}, 32'd0);
      chk("reset_addr", {29'd0, bus.Paddr}, 32'd0);

      // write, zero wait states, slave 1
      rst            = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_write = 1'b1;
      bus.req0_addr  = 5'b01_010;
      bus.req0_wdata = 16'h00AA;
      bus.Pready_bus = 3'b010;
      tick();
      chk("wr_setup", ctl(), mk(0, 1, 0, 0, 0, 0, 0, 1, 3'b010));
      chk("wr_setup_ad", {bus.Paddr, bus.Pwdata}, {13'd0, 3'd2, 16'h00AA});
      bus.req0_valid = 1'b0;
      tick();
      chk("wr_access", ctl(), mk(0, 0, 0, 0, 0, 0, 1, 1, 3'b010));
      chk("wr_access_ad", {bus.Paddr, bus.Pwdata}, {13'd0, 3'd2, 16'h00AA});
      tick();
      chk("wr_resp", ctl(), mk(0, 0, 0, 0, 0, 0, 0, 1, 3'b000));
      tick();
      chk("wr_done", ctl(), mk(0, 0, 0, 1, 0, 0, 0, 1, 3'b000));
      chk("wr_rdata", {16'd0, bus.rdata}, 32'd0);

      // read with three wait states on slave 0; other slaves ready
      bus.req1_valid = 1'b1;
      bus.req1_write = 1'b0;
      bus.req1_addr  = 5'b00_011;
      bus.Pready_bus = 3'b110;
      tick();
      chk("rd_ack", ctl(), mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b001));
      bus.req1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rd_access", ctl(), mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b001));
         chk("rd_paddr", {29'd0, bus.Paddr}, 32'd3);
         if (i == 3) bus.Pready_bus = 3'b001;
      end
      tick();
      chk("rd_resp", ctl(), mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
      chk("rd_resp_data", {16'd0, bus.rdata}, 32'h1234);
      bus.Pready_bus = 3'b000;
      tick();
      chk("rd_done", ctl(), mk(0, 0, 1, 0, 0, 0, 0, 0, 3'b000));
      chk("rd_done_data", {16'd0, bus.rdata}, 32'h1234);

      // decode error: slave 3 does not exist
      bus.req0_valid = 1'b1;
      bus.req0_write = 1'b0;
      bus.req0_addr  = 5'b11_000;
      tick();
      chk("dec_ack", ctl(), mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b000));
      bus.req0_valid = 1'b0;
      tick();
      chk("dec_done", ctl(), mk(0, 0, 0, 1, 0, 1, 0, 0, 3'b000));
      chk("dec_rdata", {16'd0, bus.rdata}, 32'h1234);

      // contention from reset with both requesters re-requesting
      rst            = 1'b1;
      bus.req0_valid = 1'b1;
      bus.req0_write = 1'b1;
      bus.req0_addr  = 5'b10_001;
      bus.req0_wdata = 16'h1111;
      bus.req1_valid = 1'b1;
      bus.req1_write = 1'b1;
      bus.req1_addr  = 5'b01_100;
      bus.req1_wdata = 16'h2222;
      bus.Pready_bus = 3'b111;
      tick();
      chk("rst2_ctl", ctl(), 32'd0);
      chk("rst2_rdata", {16'd0, bus.rdata}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("one_ack", {31'd0, bus.req0_ack & bus.req1_ack}, 32'd0);
         chk("psel_1hot", {31'd0, $countones(bus.Psel) > 1}, 32'd0);
         chk("pen_wo_psel", {31'd0, bus.Penable & ~|bus.Psel}, 32'd0);
         if (bus.req0_ack) begin
            g.push_back(0);
            chk("c0_psel", {29'd0, bus.Psel}, 32'd4);
         end
         if (bus.req1_ack) begin
            g.push_back(1);
            chk("c1_psel", {29'd0, bus.Psel}, 32'd2);
         end
      end
      chk("grant_cnt", g.size(), 32'd4);
      foreach (g[i]) chk("grant_order", g[i], i % 2);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;

      // reset while waiting in ACCESS
      bus.req0_valid = 1'b1;
      bus.req0_write = 1'b0;
      bus.req0_addr  = 5'b00_001;
      bus.Pready_bus = 3'b000;
      tick();
      bus.req0_valid = 1'b0;
      tick(2);
      chk("mid_access", ctl(), mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b001));
      rst = 1'b1;
      tick();
      chk("mid_rst_ctl", ctl(), 32'd0);
      chk("mid_rst_ad", {bus.Paddr, bus.Pwdata}, 32'd0);
      rst            = 1'b0;
      bus.Pready_bus = 3'b111;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("no_done", ctl(), 32'd0);
      end
      bus.req0_valid = 1'b1;
      bus.req0_write = 1'b1;
      bus.req0_addr  = 5'b01_101;
      bus.req0_wdata = 16'h3333;
      bus.req1_valid = 1'b1;
      bus.req1_write = 1'b1;
      bus.req1_addr  = 5'b10_110;
      bus.req1_wdata = 16'h4444;
      tick();
      chk("tie_after_rst", ctl(), mk(0, 1, 0, 0, 0, 0, 0, 1, 3'b010));
      chk("tie_ad", {bus.Paddr, bus.Pwdata}, {13'd0, 3'd5, 16'h3333});
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick(3);
      chk("tie_done", ctl(), mk(0, 0, 0, 1, 0, 0, 0, 1, 3'b000));

      // slave 0 never ready
      bus.req1_valid = 1'b1;
      bus.req1_write = 1'b0;
      bus.req1_addr  = 5'b00_000;
      bus.Pready_bus = 3'b000;
      tick();
      chk("hang_ack", ctl(), mk(1, 0, 0, 0, 0, 0, 0, 0, 3'b001));
      bus.req1_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
      begin
         int n = 1;
         while (!bus.req1_done && n < 60) begin
            tick();
            n++;
         end
         chk("to_latency", n, 32'd34);
         chk("to_done", ctl(), mk(0, 0, 1, 0, 1, 0, 0, 0, 3'b000));
         chk("to_rdata", {16'd0, bus.rdata}, 32'd0);
      end
`else
      tick(100);
      chk("no_timeout", ctl(), mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b001));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
